// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring with a halt flag, opcode decode to the 12-bit control word.
// Optional build macro SAP_VAR_CYCLE_EN shortens instructions by returning to T1 after their last useful state.
module sap_controller (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [3:0]  ir_op,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        demux_sel,
  output logic        halted
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] LM = 12'h200;
  localparam logic [11:0] CE = 12'h100;
  localparam logic [11:0] LI = 12'h080;
  localparam logic [11:0] EI = 12'h040;
  localparam logic [11:0] LA = 12'h020;
  localparam logic [11:0] EA = 12'h010;
  localparam logic [11:0] SU = 12'h008;
  localparam logic [11:0] EU = 12'h004;
  localparam logic [11:0] LB = 12'h002;
  localparam logic [11:0] LO = 12'h001;

  logic [5:0] t_reg;
  logic [5:0] t_next;
  logic       halt_reg;
  logic       halt_next;
  logic       is_mem_op;

  assign is_mem_op = (ir_op == OP_LDA) || (ir_op == OP_ADD) || (ir_op == OP_SUB);

  always_comb begin
    t_next    = {t_reg[4:0], t_reg[5]};
    halt_next = halt_reg;
`ifdef SAP_VAR_CYCLE_EN
    // Early return to fetch once the instruction has no further useful work.
    if (t_reg[3] && ((ir_op == OP_OUT) || (!is_mem_op && (ir_op != OP_HLT))))
      t_next = T1;
    if (t_reg[4] && (ir_op == OP_LDA))
      t_next = T1;
`endif
    if (t_reg[3] && (ir_op == OP_HLT)) begin
      t_next    = '0;
      halt_next = 1'b1;
    end
    if (halt_reg) begin
      t_next    = '0;
      halt_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      t_reg    <= T1;
      halt_reg <= 1'b0;
    end else begin
      t_reg    <= t_next;
      halt_reg <= halt_next;
    end
  end

  always_comb begin
    con = '0;
    if (!halt_reg) begin
      if (t_reg[0]) con = EP | LM;
      if (t_reg[1]) con = CP;
      if (t_reg[2]) con = CE | LI;
      if (t_reg[3]) begin
        if (is_mem_op)            con = EI | LM;
        else if (ir_op == OP_OUT) con = EA | LO;
      end
      if (t_reg[4]) begin
        if (ir_op == OP_LDA)                             con = CE | LA;
        else if ((ir_op == OP_ADD) || (ir_op == OP_SUB)) con = CE | LB;
      end
      if (t_reg[5]) begin
        if (ir_op == OP_ADD)      con = LA | EU;
        else if (ir_op == OP_SUB) con = LA | SU | EU;
      end
    end
  end

  assign t_state   = t_reg;
  assign demux_sel = ~con[6];
  assign halted    = halt_reg;

endmodule

// File: doc/sap_controller.md
# sap_controller

Controller-sequencer for the SAP-1 datapath. It is a six-state ring counter (T1–T6) with a halt state, and it decodes the instruction-register opcode into the 12-bit control word. It also drives the select input of the instruction-register nibble demultiplexer, so the operand address reaches the W bus only while `ei` is asserted.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; all state updates on rising edge
- `clr_n`  in  1  reset, **synchronous, active-low**; one clock, no other clock domains
- `ir_op`  in  4  opcode nibble, the instruction register's upper nibble
- `con`  out  12  control word, all bits active-high
  - [11] `cp`, [10] `ep`, [9] `lm`, [8] `ce`
  - [7] `li`, [6] `ei`, [5] `la`, [4] `ea`
  - [3] `su`, [2] `eu`, [1] `lb`, [0] `lo`
- `t_state`  out  6  one-hot current T-state: bit0 = T1 … bit5 = T6; all-zero while halted
- `demux_sel`  out  1  demux select: 1 routes the nibble to the opcode side (A), 0 routes it to the bus side (B)
- `halted`  out  1  high while in the HALT state

## Operation
- States: T1..T6 and HALT, held in a registered one-hot ring plus a halt flag.
- `con` and `demux_sel` are combinational from the registered state and `ir_op`.
- Fetch cycle, independent of opcode:
  - T1: `ep`, `lm`
  - T2: `cp`
  - T3: `ce`, `li`
- Execute cycle, decoded from `ir_op` in T4–T6:
  - LDA `0000`: T4 `ei lm`; T5 `ce la`; T6 none
  - ADD `0001`: T4 `ei lm`; T5 `ce lb`; T6 `la eu`
  - SUB `0010`: T4 `ei lm`; T5 `ce lb`; T6 `la su eu`
  - OUT `1110`: T4 `ea lo`; T5–T6 none
  - HLT `1111`: T4 none; the edge ending T4 enters HALT
  - Any other opcode: NOP, `con` = 0 in T4–T6
- `demux_sel` = NOT `ei`. It is 0 only in T4 of LDA/ADD/SUB.
- Transitions:
  - T1→T2→…→T6→T1.
  - T4 with HLT → HALT.
  - HALT → HALT until reset.
- In HALT: `con` = 0, `t_state` = 0, `demux_sel` = 1, `halted` = 1. Changes on `ir_op` have no effect.

## Timing
- Reset: at a rising edge with `clr_n` = 0, the block enters T1 and clears the halt flag. This holds from any state, including mid-instruction and HALT.
- Post-reset outputs:
  - `t_state` = 6'b000001
  - `con` = 12'h600 (`ep` | `lm`)
  - `demux_sel` = 1
  - `halted` = 0
- While `clr_n` is held low, the outputs stay at these values every cycle.
- The first release edge (`clr_n` = 1) advances to T2.
- One T-state per clock. Outputs become valid after the clock-to-output delay of the edge that enters the state.
- `ir_op` must be stable during T4–T6. The instruction register loads on the edge ending T3, so `ir_op` is new from T4 onward.
- A change in `ir_op` during T4–T6 changes `con` in the same cycle; there is no latching.
- `halted` rises on the edge ending T4 of HLT and is registered.

## Configuration
- `SAP_VAR_CYCLE_EN` **undefined**: every instruction takes exactly 6 T-states; unused states output `con` = 0.
- `SAP_VAR_CYCLE_EN` **defined**: the ring returns to T1 after the last useful state.
  - LDA: after T5 (5 clocks)
  - ADD/SUB: after T6 (6 clocks)
  - OUT: after T4 (4 clocks)
  - Undefined opcodes: after T4 (4 clocks)
  - HLT: behaviour unchanged.
- Both builds produce identical `con` values in every state that is visited.

## Test plan
- **Reset/fetch:** hold `clr_n` = 0 for 2 clocks, then release with `ir_op` = `0000`.
  - Required: `t_state` 000001, 000010, 000100 on consecutive cycles.
  - Required: `con` = 600, 800, 180 (hex).
- **LDA:** `ir_op` = `0000`. T4 `con` = 240 with `demux_sel` = 0; T5 `con` = 120 with `demux_sel` = 1.
  - Macro off: T6 `con` = 000, then T1.
  - Macro on: T5 is followed by T1.
- **SUB:** `ir_op` = `0010`. T4 = 240, T5 = 102, T6 = 02C.
  - Next `t_state` = 000001 in both builds.
- **OUT then HLT:** `ir_op` = `1110` gives T4 `con` = 011. Next instruction, `ir_op` = `1111`.
  - Required: after T4, `halted` = 1, `t_state` = 0, `con` = 0.
  - These values hold for 20 clocks while `ir_op` toggles.
- **Reset mid-op:** assert `clr_n` = 0 for one edge during T5 of ADD.
  - Required: next cycle is T1 with `con` = 600.
  - The same reset applied from HALT clears `halted` to 0.
- **Undefined opcode:** `ir_op` = `0111` gives `con` = 0 in T4–T6 and `demux_sel` = 1 throughout.
  - Macro on: returns to T1 after T4.
